pwm_device_controller: RTL

- Sequences one PWM device: a prescaler, a shared up-counter and OUTPUTS compare channels.
- Configured over the peripheral register bus.
- Holds double-buffered (shadow/active) top and compare registers so that software updates take effect only at a period boundary.
- Sits between the peripheral bus decoder and the PWM output pins routed to mprj_io.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_prescaler_counter.sv | 46 ++++
 rtl/pwm_device_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared register map and config field positions for the PWM device controller.
package pwm_pkg;

  localparam logic [3:0] ADDR_CONFIG       = 4'd0;
  localparam logic [3:0] ADDR_TOP          = 4'd1;
  localparam logic [3:0] ADDR_COUNTER      = 4'd2;
  localparam logic [3:0] ADDR_STATUS       = 4'd3;
  localparam logic [3:0] ADDR_COMPARE_BASE = 4'd4;

  localparam int CFG_ENABLE_BIT = 0;
  localparam int CFG_SCALE_LSB  = 4;
  localparam int CFG_IRQ_EN_BIT = 8;
  localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/pwm_prescaler_counter.sv
// Prescaler and shared period counter; tick fires every (scale+1) cycles while
// running, wrap fires on the tick where the counter equals the active top.
module pwm_prescaler_counter #(
  parameter int WIDTH      = 16,
  parameter int SCALE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [SCALE_BITS-1:0] scale,
  input  logic                  scale_load,
  input  logic [WIDTH-1:0]      top,
  output logic [WIDTH-1:0]      counter,
  output logic                  tick,
  output logic                  wrap
);

  logic [SCALE_BITS-1:0] presc_r;
  logic [WIDTH-1:0]      count_r;

  assign tick    = run && (presc_r == scale);
  assign wrap    = tick && (count_r == top);
  assign counter = count_r;

  // Prescaler and counter state; both held at zero whenever not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {SCALE_BITS{1'b0}};
      count_r <= {WIDTH{1'b0}};
    end else if (!run) begin
      presc_r <= {SCALE_BITS{1'b0}};
      count_r <= {WIDTH{1'b0}};
    end else begin
      // A scale change restarts the prescale interval from zero.
      presc_r <= (tick || scale_load) ? {SCALE_BITS{1'b0}} : presc_r + SCALE_BITS'(1);
      if (wrap) begin
        count_r <= {WIDTH{1'b0}};
      end else if (tick) begin
        count_r <= count_r + WIDTH'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/pwm_device_controller.sv
// PWM device controller: register file, double-buffered top/compare, compare channels.
// Optional wrap interrupt output is built when PWM_IRQ_EN is defined.
module pwm_device_controller
  import pwm_pkg::*;
#(
  parameter int OUTPUTS    = 4,
  parameter int WIDTH      = 16,
  parameter int SCALE_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_we,
  input  logic               bus_re,
  input  logic [3:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_rvalid,
  output logic [OUTPUTS-1:0] pwm_out
`ifdef PWM_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic                  enable_r;
  logic                  enable_nxt_s;
  logic                  run_s;
  logic [SCALE_BITS-1:0] scale_r;
  logic [SCALE_BITS-1:0] scale_nxt_s;
  logic                  scale_load_s;
  logic                  cfg_wr_s;
  logic                  top_wr_s;
  logic                  status_wr_s;
  logic                  load_active_s;
  logic [WIDTH-1:0]      top_shadow_r;
  logic [WIDTH-1:0]      top_shadow_nxt_s;
  logic [WIDTH-1:0]      top_active_r;
  logic [WIDTH-1:0]      cmp_shadow_r     [OUTPUTS];
  logic [WIDTH-1:0]      cmp_shadow_nxt_s [OUTPUTS];
  logic [WIDTH-1:0]      cmp_active_r     [OUTPUTS];
  logic                  wrap_flag_r;
  logic                  wrap_flag_nxt_s;
  logic [WIDTH-1:0]      counter_s;
  logic                  tick_s;
  logic                  wrap_s;
  logic [OUTPUTS-1:0]    pwm_nxt_s;
  logic [31:0]           rd_data_s;
  logic                  unused_s;
`ifdef PWM_IRQ_EN
  logic                  irq_en_r;
`endif

  assign unused_s = ^{bus_wdata, tick_s};

  pwm_prescaler_counter #(
    .WIDTH      (WIDTH),
    .SCALE_BITS (SCALE_BITS)
  ) u_presc_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (run_s),
    .scale      (scale_r),
    .scale_load (scale_load_s),
    .top        (top_active_r),
    .counter    (counter_s),
    .tick       (tick_s),
    .wrap       (wrap_s)
  );

  // Write decode and next-state of config, shadows and wrap flag.
  always_comb begin
    cfg_wr_s     = bus_we && (bus_addr == ADDR_CONFIG);
    top_wr_s     = bus_we && (bus_addr == ADDR_TOP);
    status_wr_s  = bus_we && (bus_addr == ADDR_STATUS);
    enable_nxt_s = cfg_wr_s ? bus_wdata[CFG_ENABLE_BIT] : enable_r;
    scale_nxt_s  = cfg_wr_s ? bus_wdata[CFG_SCALE_LSB +: SCALE_BITS] : scale_r;
    scale_load_s = (scale_nxt_s != scale_r);
    // Running needs enable both before and after this cycle's write, so a
    // start begins one cycle later and a stop takes hold at once.
    run_s         = enable_r && enable_nxt_s;
    load_active_s = wrap_s || !run_s;
    top_shadow_nxt_s = top_wr_s ? bus_wdata[WIDTH-1:0] : top_shadow_r;
    for (int i = 0; i < OUTPUTS; i++) begin
      cmp_shadow_nxt_s[i] = (bus_we && (bus_addr == ADDR_COMPARE_BASE + 4'(i)))
                            ? bus_wdata[WIDTH-1:0] : cmp_shadow_r[i];
      pwm_nxt_s[i]        = run_s && (counter_s >= cmp_active_r[i]);
    end
    if (wrap_s) begin
      wrap_flag_nxt_s = 1'b1;
    end else if (status_wr_s && bus_wdata[STATUS_WRAP_BIT]) begin
      wrap_flag_nxt_s = 1'b0;
    end else begin
      wrap_flag_nxt_s = wrap_flag_r;
    end
  end

  // Read mux over the pre-write register values.
  always_comb begin
    rd_data_s = 32'd0;
    case (bus_addr)
      ADDR_CONFIG: begin
        rd_data_s[CFG_ENABLE_BIT]                = enable_r;
        rd_data_s[CFG_SCALE_LSB +: SCALE_BITS]   = scale_r;
`ifdef PWM_IRQ_EN
        rd_data_s[CFG_IRQ_EN_BIT]                = irq_en_r;
`endif
      end
      ADDR_TOP:     rd_data_s = 32'(top_shadow_r);
      ADDR_COUNTER: rd_data_s = 32'(counter_s);
      ADDR_STATUS:  rd_data_s[STATUS_WRAP_BIT] = wrap_flag_r;
      default: begin
        for (int i = 0; i < OUTPUTS; i++) begin
          rd_data_s = rd_data_s | ((bus_addr == ADDR_COMPARE_BASE + 4'(i))
                                   ? 32'(cmp_shadow_r[i]) : 32'd0);
        end
      end
    endcase
  end

  // Config, shadow and active registers; actives load forwarded shadows on wrap or while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r     <= 1'b0;
      scale_r      <= {SCALE_BITS{1'b0}};
      top_shadow_r <= {WIDTH{1'b1}};
      top_active_r <= {WIDTH{1'b1}};
      wrap_flag_r  <= 1'b0;
      for (int i = 0; i < OUTPUTS; i++) begin
        cmp_shadow_r[i] <= {WIDTH{1'b0}};
        cmp_active_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      enable_r     <= enable_nxt_s;
      scale_r      <= scale_nxt_s;
      top_shadow_r <= top_shadow_nxt_s;
      top_active_r <= load_active_s ? top_shadow_nxt_s : top_active_r;
      wrap_flag_r  <= wrap_flag_nxt_s;
      for (int i = 0; i < OUTPUTS; i++) begin
        cmp_shadow_r[i] <= cmp_shadow_nxt_s[i];
        cmp_active_r[i] <= load_active_s ? cmp_shadow_nxt_s[i] : cmp_active_r[i];
      end
    end
  end

  // Registered bus read response and PWM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata  <= 32'd0;
      bus_rvalid <= 1'b0;
      pwm_out    <= {OUTPUTS{1'b0}};
    end else begin
      bus_rdata  <= bus_re ? rd_data_s : 32'd0;
      bus_rvalid <= bus_re;
      pwm_out    <= pwm_nxt_s;
    end
  end

`ifdef PWM_IRQ_EN
  // Interrupt enable and registered wrap interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_r <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_en_r <= cfg_wr_s ? bus_wdata[CFG_IRQ_EN_BIT] : irq_en_r;
      irq      <= wrap_flag_r && irq_en_r;
    end
  end
`endif

endmodule
